mc_alu: RTL and testbench

Parametrised multi-cycle ALU with valid/ready handshakes on input and output, an 8-operation set including iterative shift-add multiply, and registered status flags. It is the execution unit of the custom processor datapath. The decode stage issues one operation at a time, and writeback consumes the result and flags. Single-cycle operations complete in one clock; MUL takes WIDTH+1 clocks.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/mc_alu_mul_iter.sv | 69 ++++++
 rtl/mc_alu.sv | 159 +++++++++++++++
 tb/tb_mc_alu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the status flag layout.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mc_alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock, WIDTH steps per multiply.
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] step_sum;

    // product shows the accumulator after the current step, so it is complete while done is high
    always_comb begin
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product = step_sum;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready handshakes; single-cycle ops finish in one clock, MUL in WIDTH+1.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags
);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    alu_flags_t         flags_q, flags_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]          add_full, sub_full;
    logic [WIDTH-1:0]        sc_res;
    logic                    sc_c, sc_v;
    logic signed [WIDTH-1:0] a_s, b_s, r_s;

    function automatic alu_flags_t make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        alu_flags_t f;
        f.n = r[WIDTH-1];
        f.z = (r == '0);
        f.c = c;
        f.v = v;
        return f;
    endfunction

    assign mul_start = (state_q == ST_IDLE) && in_valid && (alu_op_e'(opcode) == OP_MUL);

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // SUB carry is the carry-out of A + ~B + 1, i.e. "no borrow"
    always_comb begin
        add_full = {1'b0, A} + {1'b0, B};
        sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        a_s      = A;
        b_s      = B;
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        case (alu_op_e'(opcode))
            OP_ADD: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
            end
            OP_SUB: begin
                sc_res = sub_full[WIDTH-1:0];
                sc_c   = sub_full[WIDTH];
            end
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_XOR: sc_res = A ^ B;
            OP_SLL: sc_res = A << B[SHW-1:0];
            OP_SRL: sc_res = A >> B[SHW-1:0];
            default: sc_res = '0;
        endcase
        r_s = sc_res;
        if (alu_op_e'(opcode) == OP_ADD) begin
            sc_v = ((a_s < 0) == (b_s < 0)) && ((r_s < 0) != (a_s < 0));
        end else if (alu_op_e'(opcode) == OP_SUB) begin
            sc_v = ((a_s < 0) != (b_s < 0)) && ((r_s < 0) != (a_s < 0));
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (alu_op_e'(opcode) == OP_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        alu_out_d   = sc_res;
                        flags_d     = make_flags(sc_res, sc_c, sc_v);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    alu_out_d   = mul_product[WIDTH-1:0];
                    flags_d     = make_flags(mul_product[WIDTH-1:0],
                                             |mul_product[2*WIDTH-1:WIDTH], 1'b0);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (!mul_busy) begin
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_out_q   <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_mc_alu.sv
// Bench for mc_alu: directed corner cases plus random ops against an arithmetic reference model.
module tb_mc_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, full, s;
        logic c, v;
        ua = a; ub = b;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        full = 0; s = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin full = ua + ub; s = sa + sb; c = (full > 65535); v = (s > 32767) || (s < -32768); end
            3'd1: begin full = ua - ub; s = sa - sb; c = (ua >= ub);     v = (s > 32767) || (s < -32768); end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: full = ua << (ub % W);
            3'd6: full = ua >> (ub % W);
            default: begin full = ua * ub; c = (full > 65535); end
        endcase
        r = full[W-1:0];
        f = {r[W-1], (r == '0), c, v};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic [3:0]   ef;
        int           lat;
        model(op, a, b, er, ef);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        opcode = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 3'($urandom); A = W'($urandom); B = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 64);
        chk({tag, "_latency"}, lat, (op == 3'd7) ? W + 1 : 1);
        chk({tag, "_result"}, alu_out, er);
        chk({tag, "_flags"}, flags, ef);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            opcode = 3'($urandom); A = W'($urandom); B = W'($urandom);
            @(negedge clk);
            chk({tag, "_hold_result"}, alu_out, er);
            chk({tag, "_hold_flags"}, flags, ef);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
            chk({tag, "_hold_out_valid"}, out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release_out_valid"}, out_valid, 0);
        chk({tag, "_release_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_alu_out", alu_out, 0);
        chk("reset_flags", flags, 0);
        rst_n = 1'b1;

        run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 0);
        chk("add_wrap_const", {alu_out, 12'h0, flags}, {16'h0000, 12'h0, 4'b0110});
        run_op("sub_ovf",  3'd1, 16'h8000, 16'h0001, 0);
        chk("sub_ovf_const", {alu_out, 12'h0, flags}, {16'h7FFF, 12'h0, 4'b0011});
        run_op("sub_neg",  3'd1, 16'h0003, 16'h0005, 0);
        run_op("mul_big",  3'd7, 16'h0100, 16'h0100, 0);
        chk("mul_big_const", {alu_out, 12'h0, flags}, {16'h0000, 12'h0, 4'b0110});
        run_op("mul_small", 3'd7, 16'h00FF, 16'h0003, 0);
        chk("mul_small_const", alu_out, 16'h02FD);
        run_op("sll",      3'd5, 16'h0001, 16'h0013, 0);
        chk("sll_const", alu_out, 16'h0008);
        run_op("srl",      3'd6, 16'h8000, 16'h000F, 0);
        chk("srl_const", alu_out, 16'h0001);
        run_op("xor",      3'd4, 16'hAAAA, 16'hFFFF, 0);
        chk("xor_const", alu_out, 16'h5555);
        run_op("and",      3'd2, 16'hF0F0, 16'h3C3C, 0);
        run_op("or",       3'd3, 16'hF000, 16'h000F, 0);
        run_op("backpressure", 3'd0, 16'h1234, 16'h4321, 5);
        run_op("mul_bp",   3'd7, 16'hFFFF, 16'hFFFF, 3);

        // Reset in the middle of a multiply
        @(negedge clk);
        opcode = 3'd7; A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_alu_out", alu_out, 0);
        chk("midreset_flags", flags, 0);
        rst_n = 1'b1;
        run_op("post_reset_add", 3'd0, 16'h0002, 16'h0003, 0);
        chk("post_reset_add_const", alu_out, 16'h0005);

        for (int k = 0; k < 40; k++) begin
            run_op("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
